// File: rtl/tiled_ycc_renderer.sv
// Tagged 4:2:2 YCbCr line-FIFO reader with a 3-stage signed, saturating RGB converter and X-tile gating.
// Optional build macro TEST_PATTERN_EN enables colour bars, gradient and black via i_mode.
module tiled_ycc_renderer #(
    parameter int H_START  = 1,
    parameter int H_ACTIVE = 1280,
    parameter int V_START  = 24,
    parameter int V_ACTIVE = 720,
    parameter int XTAG_W   = 2
) (
    input  logic                i_clk_74M,
    input  logic                i_rst,
    input  logic [11:0]         i_hcnt,
    input  logic [11:0]         i_vcnt,
    input  logic [1:0]          i_mode,
    output logic                o_fifo_read,
    input  logic [XTAG_W+26:0]  i_data,
    output logic                o_de,
    output logic [7:0]          o_r,
    output logic [7:0]          o_g,
    output logic [7:0]          o_b,
    output logic                o_sync_err,
    output logic [15:0]         o_err_cnt
);
    localparam int TILES_X = 2 ** XTAG_W;
    localparam int TILE_W  = H_ACTIVE / TILES_X;
    localparam int TPW     = $clog2(TILE_W);
    localparam logic [TPW-1:0] TILE_LAST = TPW'(TILE_W - 1);
    localparam logic [11:0] H_LO = 12'(H_START);
    localparam logic [11:0] H_HI = 12'(H_START + H_ACTIVE);
    localparam logic [11:0] V_LO = 12'(V_START);
    localparam logic [11:0] V_HI = 12'(V_START + V_ACTIVE);

    logic              active, line_start, px_odd;
    logic [10:0]       line_tag;
    logic [XTAG_W-1:0] d_xtag;
    logic [10:0]       d_ytag;
    logic [7:0]        d_y, d_c;
    logic [TPW-1:0]    tile_pos_q, tile_pos_cur;
    logic [XTAG_W-1:0] tile_idx_q, tile_idx_cur;

    always_comb begin
        active       = (i_hcnt >= H_LO) && (i_hcnt < H_HI) && (i_vcnt >= V_LO) && (i_vcnt < V_HI);
        line_start   = (i_hcnt == H_LO);
        px_odd       = i_hcnt[0] ^ H_LO[0];
        line_tag     = 11'(i_vcnt - V_LO);
        {d_xtag, d_ytag, d_y, d_c} = i_data;
        tile_pos_cur = line_start ? '0 : tile_pos_q;
        tile_idx_cur = line_start ? '0 : tile_idx_q;
    end

    assign o_fifo_read = active && !i_rst;

    // Stage 1: capture luma, chroma, tile match; track tile position; line-tag check.
    logic       v1, match1;
    logic [7:0] y1, cb_q, cr_q;

    always_ff @(posedge i_clk_74M) begin
        if (i_rst) begin
            v1         <= 1'b0;
            y1         <= 8'd0;
            match1     <= 1'b0;
            cb_q       <= 8'd128;
            cr_q       <= 8'd128;
            tile_pos_q <= '0;
            tile_idx_q <= '0;
            o_sync_err <= 1'b0;
            o_err_cnt  <= 16'd0;
        end else begin
            v1 <= active;
            if (active) begin
                y1     <= d_y;
                match1 <= (d_xtag == tile_idx_cur);
                if (px_odd) cr_q <= d_c;
                else        cb_q <= d_c;
                if (tile_pos_cur == TILE_LAST) begin
                    tile_pos_q <= '0;
                    tile_idx_q <= tile_idx_cur + 1'b1;
                end else begin
                    tile_pos_q <= tile_pos_cur + 1'b1;
                    tile_idx_q <= tile_idx_cur;
                end
                if (line_start && (d_ytag != line_tag)) begin
                    o_sync_err <= 1'b1;
                    if (o_err_cnt != 16'hFFFF) o_err_cnt <= o_err_cnt + 16'd1;
                end
            end
        end
    end

    // Stage 2: signed chroma products from the most recent Cb and Cr.
    logic signed [18:0] cbs, crs, pr, pg, pb;
    logic               v2, match2;
    logic [7:0]         y2;

    always_comb begin
        cbs = $signed({11'd0, cb_q}) - 19'sd128;
        crs = $signed({11'd0, cr_q}) - 19'sd128;
    end

    always_ff @(posedge i_clk_74M) begin
        if (i_rst) v2 <= 1'b0;
        else       v2 <= v1;
    end

    always_ff @(posedge i_clk_74M) begin
        y2     <= y1;
        match2 <= match1;
        pr     <= 19'sd359 * crs;
        pg     <= 19'sd88 * cbs + 19'sd183 * crs;
        pb     <= 19'sd454 * cbs;
    end

`ifdef TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;
    logic [1:0]  mode1, mode2;
    logic [23:0] pat_cur, pat1, pat2;
    logic [11:0] px;
    logic [2:0]  bar;

    always_comb begin
        px  = i_hcnt - H_LO;
        bar = 3'(px / 12'(BAR_W));
        case (i_mode)
            2'd1:    pat_cur = {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
            2'd2:    pat_cur = {8'd0, i_vcnt[8:1], i_hcnt[9:2]};
            default: pat_cur = 24'd0;
        endcase
    end

    always_ff @(posedge i_clk_74M) begin
        mode1 <= i_mode;
        pat1  <= pat_cur;
        mode2 <= mode1;
        pat2  <= pat1;
    end
`else
    logic unused_mode;
    assign unused_mode = ^i_mode;
`endif

    // Stage 3: sum, clamp to 0..255, tile gate, pattern select.
    function automatic logic [7:0] clamp8(input logic signed [18:0] v);
        if (v < 0)              return 8'd0;
        else if (v > 19'sd255)  return 8'd255;
        else                    return v[7:0];
    endfunction

    logic signed [18:0] ys, rs, gs, bs;
    logic [23:0]        vid_rgb, pat_rgb, rgb_nxt;
    logic               video_sel;

    always_comb begin
        ys      = $signed({11'd0, y2});
        rs      = ys + (pr >>> 8);
        gs      = ys - (pg >>> 8);
        bs      = ys + (pb >>> 8);
        vid_rgb = match2 ? {clamp8(rs), clamp8(gs), clamp8(bs)} : 24'd0;
`ifdef TEST_PATTERN_EN
        video_sel = (mode2 == 2'd0);
        pat_rgb   = pat2;
`else
        video_sel = 1'b1;
        pat_rgb   = 24'd0;
`endif
        if (!v2)            rgb_nxt = 24'd0;
        else if (video_sel) rgb_nxt = vid_rgb;
        else                rgb_nxt = pat_rgb;
    end

    always_ff @(posedge i_clk_74M) begin
        if (i_rst) begin
            o_de <= 1'b0;
            o_r  <= 8'd0;
            o_g  <= 8'd0;
            o_b  <= 8'd0;
        end else begin
            o_de <= v2;
            {o_r, o_g, o_b} <= rgb_nxt;
        end
    end
endmodule

// File: tb/tb_tiled_ycc_renderer.sv
// Directed bench for tiled_ycc_renderer: per-cycle read-strobe and 3-cycle-delayed pixel checks,
// saturation vectors, window edges, line-tag errors, mid-line reset, and patterns when built with TEST_PATTERN_EN.
module tb_tiled_ycc_renderer;
    logic        clk = 1'b0;
    logic        i_rst;
    logic [11:0] i_hcnt, i_vcnt;
    logic [1:0]  i_mode;
    logic [28:0] i_data;
    logic        o_fifo_read, o_de, o_sync_err;
    logic [7:0]  o_r, o_g, o_b;
    logic [15:0] o_err_cnt;

    int checks   = 0;
    int failures = 0;
    logic [24:0] exp_q[$];

    always #7 clk = ~clk;

    tiled_ycc_renderer dut (
        .i_clk_74M  (clk),
        .i_rst      (i_rst),
        .i_hcnt     (i_hcnt),
        .i_vcnt     (i_vcnt),
        .i_mode     (i_mode),
        .o_fifo_read(o_fifo_read),
        .i_data     (i_data),
        .o_de       (o_de),
        .o_r        (o_r),
        .o_g        (o_g),
        .o_b        (o_b),
        .o_sync_err (o_sync_err),
        .o_err_cnt  (o_err_cnt)
    );

    // One pixel clock: drive inputs, check the read strobe, then check the output of 3 cycles earlier.
    task automatic pix(input logic rst, input logic [11:0] h, input logic [11:0] v,
                       input logic [1:0] xt, input logic [10:0] yt, input logic [7:0] y, input logic [7:0] c,
                       input logic exp_rd, input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb);
        logic [24:0] exp_px;
        logic [24:0] got_px;
        i_rst  = rst;
        i_hcnt = h;
        i_vcnt = v;
        i_data = {xt, yt, y, c};
        #1;
        checks++;
        assert (o_fifo_read === exp_rd) else begin
            failures++;
            $error("FAIL fifo_read h=%0d v=%0d got=%0b exp=%0b", h, v, o_fifo_read, exp_rd);
        end
        exp_q.push_back(rst ? 25'd0 : {exp_rd, er, eg, eb});
        @(posedge clk);
        #1;
        got_px = {o_de, o_r, o_g, o_b};
        if (rst) begin
            exp_px = 25'd0;
            exp_q.delete();
            exp_q.push_back(25'd0);
            exp_q.push_back(25'd0);
        end else begin
            exp_px = exp_q.pop_front();
        end
        checks++;
        assert (got_px === exp_px) else begin
            failures++;
            $error("FAIL pixel h=%0d v=%0d got de/rgb=%0b/%h exp=%0b/%h",
                   h, v, got_px[24], got_px[23:0], exp_px[24], exp_px[23:0]);
        end
    endtask

    task automatic blank(input logic [11:0] v);
        pix(1'b0, 12'd1281, v, 2'd0, 11'd0, 8'd0, 8'd128, 1'b0, 8'd0, 8'd0, 8'd0);
        for (int i = 0; i < 3; i++)
            pix(1'b0, 12'd0, v, 2'd0, 11'd0, 8'd0, 8'd128, 1'b0, 8'd0, 8'd0, 8'd0);
    endtask

    // Full line of constant Y/C; expected colour appears only in the tile named by xt.
    task automatic full_line(input logic [11:0] v, input logic [1:0] xt, input logic [10:0] yt,
                             input logic [7:0] y, input logic [7:0] c, input logic [7:0] ev);
        for (int p = 0; p < 1280; p++) begin
            if ((p / 320) == int'(xt))
                pix(1'b0, 12'(p + 1), v, xt, yt, y, c, 1'b1, ev, ev, ev);
            else
                pix(1'b0, 12'(p + 1), v, xt, yt, y, c, 1'b1, 8'd0, 8'd0, 8'd0);
        end
        blank(v);
    endtask

    task automatic chk_err(input string tag, input logic exp_flag, input logic [15:0] exp_cnt);
        checks++;
        assert (o_sync_err === exp_flag) else begin
            failures++;
            $error("FAIL %s sync_err got=%0b exp=%0b", tag, o_sync_err, exp_flag);
        end
        checks++;
        assert (o_err_cnt === exp_cnt) else begin
            failures++;
            $error("FAIL %s err_cnt got=%0d exp=%0d", tag, o_err_cnt, exp_cnt);
        end
    endtask

    initial begin
        i_mode = 2'd0;
        i_rst  = 1'b1;
        i_hcnt = 12'd0;
        i_vcnt = 12'd0;
        i_data = '0;

        // Reset held with counters in-window: strobe must stay low, outputs zero.
        for (int i = 0; i < 3; i++)
            pix(1'b1, 12'd1, 12'd24, 2'd0, 11'd0, 8'd128, 8'd128, 1'b0, 8'd0, 8'd0, 8'd0);
        chk_err("reset", 1'b0, 16'd0);

        // Left edge just outside, then neutral grey line in tile 0.
        pix(1'b0, 12'd0, 12'd24, 2'd0, 11'd0, 8'd128, 8'd128, 1'b0, 8'd0, 8'd0, 8'd0);
        full_line(12'd24, 2'd0, 11'd0, 8'd128, 8'd128, 8'd128);

        // Saturation and signed-shift vectors, line 1.
        pix(1'b0, 12'd1, 12'd25, 2'd0, 11'd1, 8'd16,  8'd128, 1'b1, 8'd16,  8'd16,  8'd16);
        pix(1'b0, 12'd2, 12'd25, 2'd0, 11'd1, 8'd16,  8'd128, 1'b1, 8'd16,  8'd16,  8'd16);
        pix(1'b0, 12'd3, 12'd25, 2'd0, 11'd1, 8'd255, 8'd128, 1'b1, 8'd255, 8'd255, 8'd255);
        pix(1'b0, 12'd4, 12'd25, 2'd0, 11'd1, 8'd255, 8'd255, 1'b1, 8'd255, 8'd165, 8'd255);
        pix(1'b0, 12'd5, 12'd25, 2'd0, 11'd1, 8'd0,   8'd0,   1'b1, 8'd178, 8'd0,   8'd0);
        pix(1'b0, 12'd6, 12'd25, 2'd0, 11'd1, 8'd0,   8'd128, 1'b1, 8'd0,   8'd44,  8'd0);
        pix(1'b0, 12'd7, 12'd25, 2'd0, 11'd1, 8'd200, 8'd128, 1'b1, 8'd200, 8'd200, 8'd200);
        blank(12'd25);

        // Third correct line, grey only in tile 2.
        full_line(12'd26, 2'd2, 11'd2, 8'd128, 8'd128, 8'd128);
        chk_err("three_good_lines", 1'b0, 16'd0);

        // Vertical window edges.
        pix(1'b0, 12'd5, 12'd744, 2'd0, 11'd0, 8'd128, 8'd128, 1'b0, 8'd0, 8'd0, 8'd0);
        pix(1'b0, 12'd5, 12'd23,  2'd0, 11'd0, 8'd128, 8'd128, 1'b0, 8'd0, 8'd0, 8'd0);
        blank(12'd23);

        // Wrong ytag on line 3 (sent 5).
        for (int p = 0; p < 4; p++)
            pix(1'b0, 12'(p + 1), 12'd27, 2'd0, 11'd5, 8'd128, 8'd128, 1'b1, 8'd128, 8'd128, 8'd128);
        blank(12'd27);
        chk_err("bad_tag", 1'b1, 16'd1);

        // Correct line afterwards: error state sticks.
        for (int p = 0; p < 4; p++)
            pix(1'b0, 12'(p + 1), 12'd28, 2'd0, 11'd4, 8'd128, 8'd128, 1'b1, 8'd128, 8'd128, 8'd128);
        blank(12'd28);
        chk_err("sticky", 1'b1, 16'd1);

        // One-cycle reset mid-line: 3 dead cycles, then output resumes.
        for (int p = 0; p < 10; p++)
            pix(1'b0, 12'(p + 1), 12'd29, 2'd0, 11'd5, 8'd128, 8'd128, 1'b1, 8'd128, 8'd128, 8'd128);
        pix(1'b1, 12'd11, 12'd29, 2'd0, 11'd5, 8'd128, 8'd128, 1'b0, 8'd0, 8'd0, 8'd0);
        for (int p = 11; p < 20; p++)
            pix(1'b0, 12'(p + 1), 12'd29, 2'd0, 11'd5, 8'd128, 8'd128, 1'b1, 8'd128, 8'd128, 8'd128);
        blank(12'd29);
        chk_err("after_reset", 1'b0, 16'd0);

`ifdef TEST_PATTERN_EN
        i_mode = 2'd1;
        pix(1'b0, 12'd1,    12'd40, 2'd0, 11'd16, 8'd0, 8'd128, 1'b1, 8'd255, 8'd255, 8'd255);
        pix(1'b0, 12'd1280, 12'd40, 2'd0, 11'd16, 8'd0, 8'd128, 1'b1, 8'd0,   8'd0,   8'd0);
        i_mode = 2'd2;
        pix(1'b0, 12'h100,  12'h040, 2'd0, 11'd0, 8'd0, 8'd128, 1'b1, 8'h00, 8'h20, 8'h40);
        i_mode = 2'd3;
        pix(1'b0, 12'd5,    12'd40, 2'd0, 11'd16, 8'd200, 8'd128, 1'b1, 8'd0, 8'd0, 8'd0);
        i_mode = 2'd0;
        blank(12'd40);
        chk_err("patterns", 1'b0, 16'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tiled_ycc_renderer.md
# tiled_ycc_renderer

Parametrised pixel back-end that pulls tagged 4:2:2 YCbCr words from the line FIFO during the active window and converts them to 8-bit RGB. It uses a fixed-latency, signed, two-sided-saturating pipeline. Each word carries an X-tile tag, and the word is shown only inside the matching horizontal tile; every other pixel in the window is black. It sits between the frame FIFO and the HDMI/DVI encoder on the 74.25 MHz pixel clock, driven by the video timing generator's counters.

## Interface
- H_START, 1, first active horizontal count
- H_ACTIVE, 1280, active pixels per line
- V_START, 24, first active line count
- V_ACTIVE, 720, active lines per frame
- XTAG_W, 2, tile-tag width; tile count TILES_X = 2**XTAG_W, tile width TILE_W = H_ACTIVE / TILES_X (must divide exactly)
- i_clk_74M  in  1  pixel clock, 74.25 MHz
- i_rst  in  1  synchronous, active-high reset
- i_hcnt  in  12  horizontal counter
- i_vcnt  in  12  vertical counter
- i_mode  in  2  0 video, 1 colour bars, 2 gradient, 3 black
- o_fifo_read  out  1  FIFO pop strobe (first-word-fall-through FIFO)
- i_data  in  XTAG_W+27  {xtag, ytag[10:0], Y[7:0], C[7:0]}
- o_de  out  1  output pixel valid, aligned with o_r/o_g/o_b
- o_r, o_g, o_b  out  8 each  RGB pixel
- o_sync_err  out  1  sticky line-tag mismatch flag
- o_err_cnt  out  16  saturating line-tag mismatch count

## Operation
- Window: active = (H_START ≤ i_hcnt < H_START+H_ACTIVE) && (V_START ≤ i_vcnt < V_START+V_ACTIVE). The compare is combinational.
- o_fifo_read = active. It does not depend on i_mode. i_data is valid in the same cycle as o_fifo_read.
- px = i_hcnt − H_START.
  - Tile index = px / TILE_W, computed with a tile counter that resets at H_START, not a divider.
  - Chroma: even px carries Cb, odd px carries Cr. Each is held in its own register. Conversion uses the latest Cb and Cr.
- Conversion, signed, with cb = Cb−128 and cr = Cr−128:
  - R = Y + (359·cr ≫ 8)
  - G = Y − ((88·cb + 183·cr) ≫ 8)
  - B = Y + (454·cb ≫ 8)
  - Arithmetic shift. Intermediates are at least 19 bits signed.
  - Clamp: negative → 0, > 255 → 255.
- Tile gating: if xtag ≠ tile index, RGB = 0 in mode 0. o_de is still 1.
- Line check: at px = 0, compare ytag with (i_vcnt − V_START)[10:0]. On mismatch:
  - Set o_sync_err.
  - Increment o_err_cnt, saturating at 0xFFFF.
  - Both hold until reset.
- Patterns (TEST_PATTERN_EN only):
  - Mode 1: eight vertical bars, each H_ACTIVE/8 wide, in order white, yellow, cyan, green, magenta, red, blue, black, using 0/255 components.
  - Mode 2: R = 0, G = i_vcnt[8:1], B = i_hcnt[9:2].
  - Mode 3: all zero.
- Outside the window: o_de = 0, RGB = 0.

## Timing
- Latency: exactly 3 cycles from a cycle with o_fifo_read = 1 to the matching o_de/RGB.
  - Stage 1: capture data, chroma and tile match.
  - Stage 2: products.
  - Stage 3: sum, clamp, gate.
- Pattern and black paths are delayed to the same 3 cycles.
- i_mode is sampled in stage 1. A change takes effect on the next pixel with no glitch.
- Reset values: o_de 0, o_r/o_g/o_b 0, o_sync_err 0, o_err_cnt 0.
  - Chroma registers reset to 128.
  - Pipeline valid bits reset to 0.
  - o_fifo_read is 0 whenever i_rst = 1.
- Reset mid-line: the pipeline flushes. Output resumes at the next in-window pixel with full 3-cycle latency.
- Line-check priority: a mismatch in the same cycle as o_err_cnt = 0xFFFF leaves the count at 0xFFFF and sets o_sync_err.
- First pixel of a line: Cr still holds the previous line's last value. This is accepted behaviour.

## Configuration
- TEST_PATTERN_EN defined: i_mode fully honoured as described above.
- TEST_PATTERN_EN undefined: i_mode ignored, video (mode 0) always. No pattern logic is synthesised.

## Test plan
- Video, XTAG_W = 2, Y = 128, C = 128 for all px, xtag = 0:
  - px 0–319 → RGB (128,128,128), o_de = 1, 3 cycles after o_fifo_read.
  - px 320–1279 → (0,0,0).
- Saturation:
  - Y = 255, Cr = 255 → R = 255.
  - Y = 0, Cb = 0 → B = 0.
  - Y = 16, Cb = 128, Cr = 128 → (16,16,16).
- Window edges:
  - i_hcnt = H_START−1 / H_START / H_START+H_ACTIVE → o_fifo_read 0 / 1 / 0.
  - i_vcnt = V_START+V_ACTIVE → o_fifo_read 0.
- Line tag:
  - Correct ytag for 3 lines → o_err_cnt = 0.
  - One wrong ytag → o_err_cnt = 1, o_sync_err = 1, remains 1 after subsequent correct lines.
- With TEST_PATTERN_EN:
  - Mode 1 → px 0 gives (255,255,255), px H_ACTIVE−1 gives (0,0,0).
  - Mode 2 at hcnt = 0x100, vcnt = 0x40 → (0, 0x20, 0x40), after 3 cycles.
- Assert i_rst for 1 cycle mid-line → o_de = 0 for the next 3 cycles, then output resumes. o_err_cnt = 0.
